// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared types and constants for the CPU bus unit: FSM state encoding,
//   channel identifiers, error counter width and its saturating increment.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_t;

   localparam logic CH_IF = 1'b0;
   localparam logic CH_LS = 1'b1;

   localparam int ERR_CNT_W = 8;

   // Saturating increment used by the timeout error counter.
   function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt
//   Access watchdog. Down-counter loaded while clr is high and decremented
//   while en is high; expired flags the en cycle in which the terminal count
//   is reached, i.e. the TIMEOUT-th enabled cycle after a clear.
//   TIMEOUT = 0 removes the counter and holds expired low.
// Ports
//   sys_clk  in   clock, rising edge
//   sys_rst  in   asynchronous active-high reset
//   clr      in   reload the counter
//   en       in   count this cycle
//   expired  out  terminal count reached in this enabled cycle
module bus_timeout_cnt #(
   parameter int TIMEOUT = 15
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{sys_clk, sys_rst, clr, en};
         assign expired = 1'b0;
      end else begin : g_on
         // Loading TIMEOUT-1 makes the count hit zero in the TIMEOUT-th
         // enabled cycle, so the compare is against a constant zero.
         localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

         logic [CNT_W-1:0] cnt;

         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= LOAD_VAL;
            end else if (en && (cnt != '0)) begin
               cnt <= cnt - CNT_W'(1);
            end
         end

         assign expired = en && (cnt == '0);
      end
   endgenerate

endmodule

// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit
//   Sequencer between the core's fetch (IF) and load/store (LS) ports and a
//   single stb/ack memory port. Round-robin arbitration, wait-state tolerant
//   accesses, optional timeout abort with saturating error count, and a
//   stall output for the core.
// Ports
//   sys_clk, sys_rst                     clock / async active-high reset
//   if_req_i, if_addr_i                  fetch request (held until done)
//   if_rdata_o, if_done_o, if_err_o      fetch response (one-cycle done)
//   ls_req_i, ls_we_i, ls_addr_i,
//   ls_wdata_i                           load/store request (held until done)
//   ls_rdata_o, ls_done_o, ls_err_o      load/store response
//   bus_addr_o, bus_data_o, bus_we_o,
//   bus_stb_o                            memory port request side
//   bus_data_i, bus_ack_i                memory port response side
//   stall_o                              request pending, response not in RESP
//   err_cnt_o                            saturating timeout count
//
//   state  | meaning
//   IDLE   | sample requests, arbitrate, latch the winning request
//   ACCESS | strobe the bus, wait for ack or timeout
//   RESP   | one-cycle done (and err) to the granted channel
module cpu_bus_unit
   import cpu_bus_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,

   input  logic                 if_req_i,
   input  logic [ADDR_W-1:0]    if_addr_i,
   output logic [DATA_W-1:0]    if_rdata_o,
   output logic                 if_done_o,
   output logic                 if_err_o,

   input  logic                 ls_req_i,
   input  logic                 ls_we_i,
   input  logic [ADDR_W-1:0]    ls_addr_i,
   input  logic [DATA_W-1:0]    ls_wdata_i,
   output logic [DATA_W-1:0]    ls_rdata_o,
   output logic                 ls_done_o,
   output logic                 ls_err_o,

   output logic [ADDR_W-1:0]    bus_addr_o,
   output logic [DATA_W-1:0]    bus_data_o,
   input  logic [DATA_W-1:0]    bus_data_i,
   output logic                 bus_stb_o,
   output logic                 bus_we_o,
   input  logic                 bus_ack_i,

   output logic                 stall_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   bus_state_t state;

   // Channel of the current/most recent access; doubles as the round-robin
   // history, so it resets to IF and LS wins the first contention.
   logic grant_ch;
   logic pick_ch;
   logic tmo_expired;

   assign pick_ch = (if_req_i && ls_req_i) ? ((grant_ch == CH_IF) ? CH_LS : CH_IF)
                  : (ls_req_i ? CH_LS : CH_IF);

   assign stall_o = (if_req_i | ls_req_i) & (state != RESP);

   bus_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (state != ACCESS),
      .en      (state == ACCESS),
      .expired (tmo_expired)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         grant_ch   <= CH_IF;
         bus_addr_o <= '0;
         bus_data_o <= '0;
         bus_we_o   <= 1'b0;
         bus_stb_o  <= 1'b0;
         if_rdata_o <= '0;
         ls_rdata_o <= '0;
         if_done_o  <= 1'b0;
         ls_done_o  <= 1'b0;
         if_err_o   <= 1'b0;
         ls_err_o   <= 1'b0;
         err_cnt_o  <= '0;
      end else begin
         if_done_o <= 1'b0;
         ls_done_o <= 1'b0;
         if_err_o  <= 1'b0;
         ls_err_o  <= 1'b0;

         case (state)
            IDLE: begin
               if (if_req_i || ls_req_i) begin
                  grant_ch  <= pick_ch;
                  bus_stb_o <= 1'b1;
                  state     <= ACCESS;
                  if (pick_ch == CH_LS) begin
                     bus_addr_o <= ls_addr_i;
                     bus_we_o   <= ls_we_i;
                     bus_data_o <= ls_wdata_i;
                  end else begin
                     bus_addr_o <= if_addr_i;
                     bus_we_o   <= 1'b0;
                     bus_data_o <= '0;
                  end
               end
            end

            ACCESS: begin
               // Ack takes priority over an expiry in the same cycle.
               if (bus_ack_i || tmo_expired) begin
                  bus_stb_o <= 1'b0;
                  state     <= RESP;
                  if (grant_ch == CH_LS) begin
                     ls_done_o <= 1'b1;
                     ls_err_o  <= !bus_ack_i;
                  end else begin
                     if_done_o <= 1'b1;
                     if_err_o  <= !bus_ack_i;
                  end

                  if (!bus_ack_i) begin
                     err_cnt_o <= err_cnt_inc(err_cnt_o);
                     if (grant_ch == CH_LS) begin
                        ls_rdata_o <= '1;
                     end else begin
                        if_rdata_o <= '1;
                     end
                  end else if (!bus_we_o) begin
                     if (grant_ch == CH_LS) begin
                        ls_rdata_o <= bus_data_i;
                     end else begin
                        if_rdata_o <= bus_data_i;
                     end
                  end
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               bus_stb_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb_cpu_bus_unit
//   Scoreboard bench for cpu_bus_unit. Requests are predicted into a queue in
//   the order the round-robin rule serves them; a monitor pops one entry per
//   done pulse. The memory slave's behaviour is a pure function of the
//   address: low three bits select the wait states (5 -> ack on the last
//   allowed cycle, 6 -> 3 waits, 7 -> never ack) and read data is addr^0xBEAF.
module tb_cpu_bus_unit;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              if_req_i = 1'b0;
   logic [ADDR_W-1:0] if_addr_i = '0;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_done_o, if_err_o;
   logic              ls_req_i = 1'b0;
   logic              ls_we_i = 1'b0;
   logic [ADDR_W-1:0] ls_addr_i = '0;
   logic [DATA_W-1:0] ls_wdata_i = '0;
   logic [DATA_W-1:0] ls_rdata_o;
   logic              ls_done_o, ls_err_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [DATA_W-1:0] bus_data_o;
   logic [DATA_W-1:0] bus_data_i;
   logic              bus_stb_o, bus_we_o;
   logic              bus_ack_i;
   logic              stall_o;
   logic [7:0]        err_cnt_o;

   always #5 sys_clk = ~sys_clk;

   cpu_bus_unit #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_rdata_o (if_rdata_o),
      .if_done_o  (if_done_o),
      .if_err_o   (if_err_o),
      .ls_req_i   (ls_req_i),
      .ls_we_i    (ls_we_i),
      .ls_addr_i  (ls_addr_i),
      .ls_wdata_i (ls_wdata_i),
      .ls_rdata_o (ls_rdata_o),
      .ls_done_o  (ls_done_o),
      .ls_err_o   (ls_err_o),
      .bus_addr_o (bus_addr_o),
      .bus_data_o (bus_data_o),
      .bus_data_i (bus_data_i),
      .bus_stb_o  (bus_stb_o),
      .bus_we_o   (bus_we_o),
      .bus_ack_i  (bus_ack_i),
      .stall_o    (stall_o),
      .err_cnt_o  (err_cnt_o)
   );

   typedef struct {
      bit          ch;      // 0 = IF, 1 = LS
      logic [15:0] addr;
      bit          we;
      logic [15:0] wdata;
      logic [15:0] rdata;
      bit          err;
      int          errcnt;
      int          burst;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   bit          m_last;     // channel served last
   logic [15:0] m_ls_rd;    // current ls_rdata_o
   int          m_errcnt;

   function automatic logic [15:0] slave_data(input logic [15:0] a);
      return a ^ 16'hBEAF;
   endfunction

   function automatic int wait_of(input logic [15:0] a);
      case (a[2:0])
         3'd5:    return 14;
         3'd6:    return 3;
         3'd7:    return -1;
         default: return int'(a[2:0]);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic predict(input bit ch, input logic [15:0] addr, input bit we,
                          input logic [15:0] wdata);
      exp_t e;
      int   w;
      w       = wait_of(addr);
      e.ch    = ch;
      e.addr  = addr;
      e.we    = ch ? we : 1'b0;
      e.wdata = wdata;
      if (w < 0 || w >= TIMEOUT) begin
         e.err    = 1'b1;
         e.rdata  = 16'hFFFF;
         e.burst  = TIMEOUT;
         m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
      end else begin
         e.err   = 1'b0;
         e.burst = w + 1;
         e.rdata = (ch && we) ? m_ls_rd : slave_data(addr);
      end
      if (ch) m_ls_rd = e.rdata;
      e.errcnt = m_errcnt;
      exp_q.push_back(e);
   endtask

   // Issue one IF and/or LS request, hold each until its done, return the
   // number of falling edges until the last done.
   task automatic run(input bit do_if, input bit do_ls, input logic [15:0] ia,
                      input logic [15:0] la, input bit lwe, input logic [15:0] lwd,
                      output int lat);
      bit ok;
      @(negedge sys_clk);
      if (do_if && do_ls) begin
         // The channel not served last goes first; the history ends unchanged.
         if (m_last == 1'b0) begin
            predict(1'b1, la, lwe, lwd);
            predict(1'b0, ia, 1'b0, 16'h0);
         end else begin
            predict(1'b0, ia, 1'b0, 16'h0);
            predict(1'b1, la, lwe, lwd);
         end
      end else if (do_if) begin
         predict(1'b0, ia, 1'b0, 16'h0);
         m_last = 1'b0;
      end else begin
         predict(1'b1, la, lwe, lwd);
         m_last = 1'b1;
      end
      if_addr_i  = ia;
      ls_addr_i  = la;
      ls_we_i    = lwe;
      ls_wdata_i = lwd;
      if_req_i   = do_if;
      ls_req_i   = do_ls;
      lat = 0;
      ok  = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge sys_clk);
         lat++;
         if (if_done_o) if_req_i = 1'b0;
         if (ls_done_o) ls_req_i = 1'b0;
         if (!if_req_i && !ls_req_i) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done_within_200_cycles");
         if_req_i = 1'b0;
         ls_req_i = 1'b0;
      end
   endtask

   // memory slave
   initial begin
      int sc;
      int w;
      sc = 0;
      bus_ack_i  = 1'b0;
      bus_data_i = '0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst || !bus_stb_o) begin
            sc         = 0;
            bus_ack_i  = 1'b0;
            bus_data_i = 16'($urandom);
         end else begin
            sc++;
            w          = wait_of(bus_addr_o);
            bus_ack_i  = (w >= 0) && (sc == w + 1);
            bus_data_i = (bus_ack_i && !bus_we_o) ? slave_data(bus_addr_o) : 16'($urandom);
         end
      end
   end

   // monitor / scoreboard
   initial begin
      int          blen;
      logic [15:0] ca, cd;
      bit          cw, stable;
      exp_t        e;
      blen = 0;
      ca = '0; cd = '0; cw = 1'b0; stable = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            blen = 0;
         end else if (bus_stb_o) begin
            if (blen == 0) begin
               ca = bus_addr_o;
               cd = bus_data_o;
               cw = bus_we_o;
               stable = 1'b1;
               check("stall_in_access", stall_o, 1);
            end else if ({bus_addr_o, bus_data_o, bus_we_o} !== {ca, cd, cw}) begin
               stable = 1'b0;
            end
            blen++;
         end else begin
            if (if_done_o || ls_done_o) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", {if_done_o, ls_done_o}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_channel", {if_done_o, ls_done_o}, e.ch ? 2'b01 : 2'b10);
                  check("rdata", e.ch ? ls_rdata_o : if_rdata_o, e.rdata);
                  check("err", e.ch ? ls_err_o : if_err_o, e.err);
                  check("err_cnt", err_cnt_o, e.errcnt);
                  check("strobe_len", blen, e.burst);
                  check("bus_addr", ca, e.addr);
                  check("bus_we", cw, e.we);
                  if (e.we) check("bus_wdata", cd, e.wdata);
                  check("bus_stable", stable, 1);
                  check("stall_in_resp", stall_o, 0);
               end
            end
            blen = 0;
         end
      end
   end

   initial begin
      int          lat;
      int          mode;
      logic [15:0] ia, la, wd;
      bit          we;
      bit          seen;

      m_last   = 1'b0;
      m_ls_rd  = '0;
      m_errcnt = 0;

      repeat (3) @(negedge sys_clk);
      check("rst_stb", bus_stb_o, 0);
      check("rst_addr", bus_addr_o, 0);
      check("rst_data", bus_data_o, 0);
      check("rst_we", bus_we_o, 0);
      check("rst_done", {if_done_o, ls_done_o, if_err_o, ls_err_o}, 0);
      check("rst_rdata", {if_rdata_o, ls_rdata_o}, 0);
      check("rst_err_cnt", err_cnt_o, 0);
      check("rst_stall", stall_o, 0);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // zero-wait load
      run(1'b0, 1'b1, 16'h0000, 16'h0040, 1'b0, 16'h0000, lat);
      check("zero_wait_latency", lat, 2);
      // store: rdata must hold 0xBEEF
      run(1'b0, 1'b1, 16'h0000, 16'h0010, 1'b1, 16'h1234, lat);
      // ack on the last allowed cycle, then a timeout
      run(1'b1, 1'b0, 16'h0105, 16'h0000, 1'b0, 16'h0000, lat);
      run(1'b1, 1'b0, 16'h0207, 16'h0000, 1'b0, 16'h0000, lat);

      // random mix of single and contending requests
      for (int i = 0; i < 150; i++) begin
         mode = int'($urandom_range(0, 2));
         ia   = 16'($urandom);
         la   = 16'($urandom);
         wd   = 16'($urandom);
         we   = 1'($urandom_range(0, 1));
         run(mode != 1, mode != 0, ia, la, we, wd, lat);
         repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end

      // drive the error counter into saturation
      for (int i = 0; i < 300; i++) begin
         ia = {13'($urandom), 3'd7};
         run(1'b1, 1'b0, ia, 16'h0000, 1'b0, 16'h0000, lat);
      end
      @(negedge sys_clk);
      check("err_cnt_saturated", err_cnt_o, 255);

      // reset in strobe cycle 2 of an access that would time out
      @(negedge sys_clk);
      if_addr_i = 16'h0307;
      if_req_i  = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge sys_clk);
         if (bus_stb_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("reset_test_strobe_seen", seen, 1);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      check("reset_drops_stb", bus_stb_o, 0);
      repeat (2) @(negedge sys_clk);
      check("reset_no_done", {if_done_o, ls_done_o}, 0);
      if_req_i = 1'b0;
      sys_rst  = 1'b0;
      m_last   = 1'b0;
      m_ls_rd  = '0;
      m_errcnt = 0;
      @(negedge sys_clk);
      check("reset_clears_err_cnt", err_cnt_o, 0);

      // contention after reset: LS, IF, LS, IF with 3 wait states each
      run(1'b1, 1'b1, 16'h0103, 16'h0203, 1'b0, 16'h0000, lat);
      run(1'b1, 1'b1, 16'h0113, 16'h0213, 1'b0, 16'h0000, lat);

      repeat (3) @(negedge sys_clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_bus_unit.md
# cpu_bus_unit

Parametrised bus unit between the CPU core's fetch and load/store stages and a single shared stb/ack memory port. It replaces fixed-width, always-ready instruction and data buses with a handshaking, wait-state-tolerant access sequencer. It provides round-robin arbitration, a bus timeout with error reporting, and a stall output for the core.

## Interface
- DATA_W, 16, bus and register data width
- ADDR_W, 16, bus address width
- TIMEOUT, 15, max cycles `bus_stb_o` is held without ack; 0 disables timeout
- sys_clk  in  1  clock, rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held until `if_done_o`
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, valid while `if_done_o`
- if_done_o  out  1  fetch response, one-cycle pulse
- if_err_o  out  1  fetch timed out, qualified by `if_done_o`
- ls_req_i  in  1  load/store request; held until `ls_done_o`
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_rdata_o  out  DATA_W  load data, valid while `ls_done_o`
- ls_done_o  out  1  load/store response, one-cycle pulse
- ls_err_o  out  1  load/store timed out, qualified by `ls_done_o`
- bus_addr_o  out  ADDR_W  bus address
- bus_data_o  out  DATA_W  bus write data
- bus_data_i  in  DATA_W  bus read data
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write enable
- bus_ack_i  in  1  bus acknowledge, sampled only while `bus_stb_o`=1
- stall_o  out  1  any request pending and its response not yet in RESP
- err_cnt_o  out  8  saturating count of timeouts

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when either request is high; the grant is latched.
  - ACCESS → RESP on `bus_ack_i` or on timeout.
  - RESP → IDLE, unconditionally.
- Requests are sampled only in IDLE.
- Arbitration when both requests are high: the channel not granted last wins.
  - `last_grant` resets to IF, so LS wins the first contention.
  - A single request is granted regardless of `last_grant`.
- On grant, the unit registers the address, `we`, wdata and channel id. The IF channel always sets `we`=0.
- ACCESS:
  - `bus_stb_o`=1. `bus_addr_o`, `bus_we_o` and `bus_data_o` are driven from the latched registers and are stable for the whole access.
- On ack, read data is captured from `bus_data_i` into the granted channel's rdata register. For a store, rdata is unchanged.
- Timeout:
  - The timer counts ACCESS cycles. If TIMEOUT≠0 and the count reaches TIMEOUT with no ack, the access is aborted.
  - On abort: rdata is set to all ones, err=1, and `err_cnt_o` increments, saturating at 255.
- RESP: the granted channel's done=1 for exactly one cycle, with err valid. `bus_stb_o`=0.
- A requester deasserting req during ACCESS does not abort the access; it completes normally.
- Back-to-back: a req still high in the IDLE after RESP is treated as a new request.
- `stall_o` = (`if_req_i` | `ls_req_i`) & !(state==RESP). This is combinational from registered state.

## Timing
- Reset values:
  - FSM in IDLE; all outputs 0 (including rdata, `err_cnt_o` and `bus_*`); timer 0; `last_grant`=IF.
- Zero-wait access:
  - Request high in cycle 0.
  - `bus_stb_o` high in cycle 1, with ack in cycle 1.
  - done in cycle 2.
  - Next grant possible in cycle 3.
- N wait states: done arrives N cycles later.
- Timeout abort: `bus_stb_o` is high for exactly TIMEOUT cycles, then RESP.
- Ack in the same cycle the timer reaches TIMEOUT: ack wins, with no error.
- Reset asserted mid-access: `bus_stb_o` drops asynchronously, no done is issued, and the access is lost.
- Timer width is `$clog2(TIMEOUT+1)`, minimum 1 bit. The timer clears on entry to ACCESS.

## Structure
- Package `cpu_bus_pkg`:
  - state enum {IDLE, ACCESS, RESP}
  - channel id constants `CH_IF`, `CH_LS`
  - err counter width constant (8)
- Sub-module `bus_timeout_cnt`: parametrised TIMEOUT counter with clear/enable inputs and an expired output; tied to constant 0 when TIMEOUT=0.
- Remaining logic (FSM, arbiter, latches) lives in `cpu_bus_unit`.

## Test plan
- Zero-wait load: ls_req, addr 0x0040; slave acks in the same cycle with 0xBEEF → `ls_done_o` in cycle 2, `ls_rdata_o`=0xBEEF, `ls_err_o`=0, `if_done_o` stays 0.
- Contention: `if_req_i` and `ls_req_i` both held high continuously; slave acks with 3 wait states → grant order LS, IF, LS, IF; each `bus_stb_o` burst is 4 cycles; `bus_addr_o` is stable throughout each burst.
- Store: ls_we=1, addr 0x0010, wdata 0x1234 → `bus_we_o`=1 and `bus_data_o`=0x1234 for the whole strobe; on done, `ls_rdata_o` keeps its previous value.
- Timeout: TIMEOUT=15, slave never acks → strobe high for 15 cycles; then `if_done_o`=1, `if_err_o`=1, `if_rdata_o`=0xFFFF, `err_cnt_o`=1. After 300 repeats, `err_cnt_o`=255.
- Ack on the last allowed cycle: ack in strobe cycle 15 → no error, `err_cnt_o` unchanged.
- Reset mid-access: assert sys_rst in strobe cycle 2 → `bus_stb_o`=0 immediately; no done pulse; after release, the first contention is granted to LS.
